// File: rtl/sram_burst_controller_if.sv
//------------------------------------------------------------------------------
// sram_burst_controller_if
//------------------------------------------------------------------------------
// Purpose : Control side of an asynchronous SRAM port. It carries the address
//           and the active-low chip enable, output enable and write enable.
//           The bidirectional data bus is a plain inout on the controller.
// Modports: master - the controller drives the address and strobes
//           slave  - the SRAM (or its model) observes them
// Params  : ADDR_W - SRAM address width (must match the controller)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sram_burst_controller_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] Ram1Addr;
  logic              Ram1EN;
  logic              Ram1OE;
  logic              Ram1WE;

  modport master (output Ram1Addr, Ram1EN, Ram1OE, Ram1WE);
  modport slave  (input  Ram1Addr, Ram1EN, Ram1OE, Ram1WE);
endinterface

`default_nettype wire

// File: rtl/sram_burst_controller.sv
//------------------------------------------------------------------------------
// sram_burst_controller
//------------------------------------------------------------------------------
// Purpose : Operator-stepped SRAM burst exerciser. The first step latches a
//           base address from SW. Each following step writes one SW word to
//           base+idx, for BURST_LEN words. The next BURST_LEN steps read those
//           words back. Each written or read word is shown on Light.
// Ports   : CLK      - system clock, rising edge
//           RST      - asynchronous active-low reset
//           SW       - operator value (base address or write data)
//           STEP     - asynchronous push button, active-high
//           Light    - last word written or read
//           Led      - active-low 7-segment (gfedcba) of idx[3:0]
//           Busy     - an SRAM access is in progress
//           Done     - the read phase is complete
//           Err      - readback checksum mismatch (SRAM_RDBK_CHECK_EN only)
//           sram     - SRAM address and strobes (interface, master)
//           Ram1Data - SRAM data bus, high-Z except while writing
// Options : `define SRAM_RDBK_CHECK_EN adds the Err port. Err is an XOR
//           checksum of the written words compared against the read words.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_burst_controller #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 18,
  parameter int BURST_LEN = 10,
  parameter int WAIT_CYC  = 1
) (
  input  wire                     CLK,
  input  wire                     RST,
  input  wire  [DATA_W-1:0]       SW,
  input  wire                     STEP,
  output logic [DATA_W-1:0]       Light,
  output logic [6:0]              Led,
  output logic                    Busy,
  output logic                    Done,
`ifdef SRAM_RDBK_CHECK_EN
  output logic                    Err,
`endif
  sram_burst_controller_if.master sram,
  inout  wire  [DATA_W-1:0]       Ram1Data
);

  // idx must be able to count up to BURST_LEN, which can be 2^ADDR_W.
  localparam logic [ADDR_W:0] c_idx_last = (ADDR_W+1)'(BURST_LEN - 1);
  localparam logic [4:0]      c_wait     = 5'(WAIT_CYC);
  localparam logic [4:0]      c_wr_last  = 5'(WAIT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_WAIT = 3'd1,
    S_WR_ACC  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RD_ACC  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            r_state;
  logic [1:0]        r_sync;
  logic              r_sync_d;
  logic              r_step;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_idx;
  logic [4:0]        r_cnt;
  logic [DATA_W-1:0] r_wdata;
  logic              r_drive;
  logic [DATA_W-1:0] r_light;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic              r_en;
  logic              r_oe;
  logic              r_we;
  logic [6:0]        r_led;
`ifdef SRAM_RDBK_CHECK_EN
  logic [DATA_W-1:0] r_wsum;
  logic [DATA_W-1:0] r_rsum;
  logic              r_err;
`endif

  logic [ADDR_W-1:0] w_sw_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_idx_lo;

  // The base address comes from the low bits of SW. It is zero-extended when
  // the SRAM is wider than the switch bank.
  if (ADDR_W <= DATA_W) begin : g_addr_trunc
    assign w_sw_addr = SW[ADDR_W-1:0];
  end else begin : g_addr_ext
    assign w_sw_addr = {{(ADDR_W-DATA_W){1'b0}}, SW};
  end

  if (ADDR_W >= 3) begin : g_idx_wide
    assign w_idx_lo = r_idx[3:0];
  end else begin : g_idx_narrow
    assign w_idx_lo = 4'(r_idx);
  end

  // This sum is truncated to ADDR_W bits, so the address wraps modulo 2^ADDR_W.
  assign w_addr = r_base + r_idx[ADDR_W-1:0];

  function automatic logic [6:0] f_seg7(input logic [3:0] v);
    logic [6:0] on;  // active-high gfedcba
    case (v)
      4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
      4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
      4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
      4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  // The STEP button feeds a two-flop synchroniser and a rising-edge detector.
  // r_step is a one-cycle pulse. Only the wait states and DONE act on it, so a
  // press that arrives during an access is dropped.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync   <= 2'b00;
      r_sync_d <= 1'b0;
      r_step   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], STEP};
      r_sync_d <= r_sync[1];
      r_step   <= r_sync[1] & ~r_sync_d;
    end
  end

  // Led follows idx one cycle late.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_led <= f_seg7(4'h0);
    else      r_led <= f_seg7(w_idx_lo);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_wdata <= '0;
      r_drive <= 1'b0;
      r_light <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_en    <= 1'b1;
      r_oe    <= 1'b1;
      r_we    <= 1'b1;
`ifdef SRAM_RDBK_CHECK_EN
      r_wsum  <= '0;
      r_rsum  <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef SRAM_RDBK_CHECK_EN
          r_wsum <= '0;
          r_rsum <= '0;
`endif
          if (r_step) begin
            r_base  <= w_sw_addr;
            r_idx   <= '0;
            r_state <= S_WR_WAIT;
          end
        end

        // Address, data and enable are launched together here. The first
        // WR_ACC cycle sets up the address and data before WE falls.
        S_WR_WAIT: begin
          if (r_step) begin
            r_wdata <= SW;
            r_addr  <= w_addr;
            r_drive <= 1'b1;
            r_en    <= 1'b0;
            r_we    <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_WR_ACC;
          end
        end

        // cnt 0        : setup, WE high
        // cnt 1..WAIT  : WE low
        // cnt WAIT+1   : hold, WE high with address and data still driven
        S_WR_ACC: begin
          if (r_cnt == c_wr_last) begin
            r_en    <= 1'b1;
            r_we    <= 1'b1;
            r_drive <= 1'b0;
            r_busy  <= 1'b0;
            r_light <= r_wdata;
`ifdef SRAM_RDBK_CHECK_EN
            r_wsum  <= r_wsum ^ r_wdata;
`endif
            if (r_idx == c_idx_last) begin
              r_idx   <= '0;
              r_state <= S_RD_WAIT;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_WR_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 5'd1;
            r_we  <= (r_cnt < c_wait) ? 1'b0 : 1'b1;
          end
        end

        S_RD_WAIT: begin
          if (r_step) begin
            r_addr  <= w_addr;
            r_en    <= 1'b0;
            r_oe    <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_RD_ACC;
          end
        end

        // cnt 0        : address setup, OE high
        // cnt 1..WAIT  : OE low. The bus is sampled on the last of these cycles.
        S_RD_ACC: begin
          if (r_cnt == c_wait) begin
            r_light <= Ram1Data;
            r_oe    <= 1'b1;
            r_en    <= 1'b1;
            r_busy  <= 1'b0;
`ifdef SRAM_RDBK_CHECK_EN
            r_rsum  <= r_rsum ^ Ram1Data;
`endif
            if (r_idx == c_idx_last) begin
              r_idx   <= '0;
              r_done  <= 1'b1;
`ifdef SRAM_RDBK_CHECK_EN
              // Compare against the sum including the word sampled right now.
              r_err   <= (r_wsum != (r_rsum ^ Ram1Data));
`endif
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_RD_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 5'd1;
            r_oe  <= 1'b0;
          end
        end

        S_DONE: begin
          if (r_step) begin
            r_done  <= 1'b0;
`ifdef SRAM_RDBK_CHECK_EN
            r_err   <= 1'b0;
`endif
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Ram1Data      = r_drive ? r_wdata : {DATA_W{1'bz}};
  assign sram.Ram1Addr = r_addr;
  assign sram.Ram1EN   = r_en;
  assign sram.Ram1OE   = r_oe;
  assign sram.Ram1WE   = r_we;
  assign Light         = r_light;
  assign Led           = r_led;
  assign Busy          = r_busy;
  assign Done          = r_done;
`ifdef SRAM_RDBK_CHECK_EN
  assign Err           = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_burst_controller.sv
//------------------------------------------------------------------------------
// tb_sram_burst_controller
//------------------------------------------------------------------------------
// Purpose : Self-checking bench for sram_burst_controller. It uses a
//           behavioural SRAM and a reference memory indexed by
//           (base + word) mod 2^ADDR_W.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_burst_controller;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 8;
  localparam int BURST_LEN = 10;
  localparam int WAIT_CYC  = 3;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] sw = '0;
  logic              step = 1'b0;
  logic [DATA_W-1:0] light;
  logic [6:0]        led;
  logic              busy;
  logic              done;
  wire  [DATA_W-1:0] ram_data;
`ifdef SRAM_RDBK_CHECK_EN
  logic              err;
`endif

  always #5 clk = ~clk;

  sram_burst_controller_if #(.ADDR_W(ADDR_W)) sram_if ();

  sram_burst_controller #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .WAIT_CYC(WAIT_CYC)
  ) dut (
    .CLK(clk), .RST(rst_n), .SW(sw), .STEP(step), .Light(light), .Led(led),
    .Busy(busy), .Done(done),
`ifdef SRAM_RDBK_CHECK_EN
    .Err(err),
`endif
    .sram(sram_if), .Ram1Data(ram_data)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural SRAM. It writes on every WE-low cycle and drives the bus while
  // OE is low. With fault_en set, a stored 0x0008 reads back with bit 0 stuck at 1.
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              fault_en = 1'b0;
  logic [DATA_W-1:0] rd_val;

  always @* begin
    rd_val = mem[sram_if.Ram1Addr];
    if (fault_en && rd_val == 16'h0008) rd_val = rd_val | 16'h0001;
  end
  assign ram_data = (!sram_if.Ram1EN && !sram_if.Ram1OE) ? rd_val : {DATA_W{1'bz}};
  always @(posedge clk) if (!sram_if.Ram1EN && !sram_if.Ram1WE) mem[sram_if.Ram1Addr] <= ram_data;

  // Bus monitor: logs writes, measures the length of each strobe-low run and
  // counts illegal cycle states.
  logic [ADDR_W-1:0] wlog_a[$];
  logic [DATA_W-1:0] wlog_d[$];
  int we_run = 0, oe_run = 0, overlap = 0, busy_bad = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      we_run = 0;
      oe_run = 0;
    end else begin
      if (!sram_if.Ram1WE && !sram_if.Ram1OE) overlap++;
      if (busy !== !sram_if.Ram1EN) busy_bad++;
      if (!sram_if.Ram1WE) begin
        if (we_run == 0) begin
          wlog_a.push_back(sram_if.Ram1Addr);
          wlog_d.push_back(ram_data);
        end
        we_run++;
      end else if (we_run != 0) begin
        check("we_low_cycles", we_run, WAIT_CYC);
        we_run = 0;
      end
      if (!sram_if.Ram1OE) oe_run++;
      else if (oe_run != 0) begin
        check("oe_low_cycles", oe_run, WAIT_CYC);
        oe_run = 0;
      end
    end
  end

  function automatic logic [6:0] seg_of(input int n);
    logic [6:0] on;
    case (n & 15)
      0: on = 7'h3F;  1: on = 7'h06;  2: on = 7'h5B;  3: on = 7'h4F;
      4: on = 7'h66;  5: on = 7'h6D;  6: on = 7'h7D;  7: on = 7'h07;
      8: on = 7'h7F;  9: on = 7'h6F; 10: on = 7'h77; 11: on = 7'h7C;
     12: on = 7'h39; 13: on = 7'h5E; 14: on = 7'h79; default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  task automatic wait_idle();
    int guard = 0;
    repeat (4) @(negedge clk);
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("busy_clear", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input logic [DATA_W-1:0] v);
    sw = v;
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    wait_idle();
  endtask

  // One real press followed by two more. The extra presses' pulses reach the
  // controller while the write access is still running.
  task automatic press_triple(input logic [DATA_W-1:0] v);
    sw = v;
    for (int k = 0; k < 6; k++) @(negedge clk) step = (k % 2 == 0);
    step = 1'b0;
    wait_idle();
  endtask

  logic [DATA_W-1:0] wdat [BURST_LEN];

  task automatic run_burst(input logic [DATA_W-1:0] base_sw, input bit triple);
    logic [ADDR_W-1:0] base, a;
    logic [DATA_W-1:0] exp, wx, rx;
    base = base_sw[ADDR_W-1:0];
    wx = '0;
    rx = '0;
    wlog_a.delete();
    wlog_d.delete();
    press(base_sw);
    for (int i = 0; i < BURST_LEN; i++) begin
      a = base + ADDR_W'(i);
      if (triple && i == 2) press_triple(wdat[i]);
      else                  press(wdat[i]);
      check("wr_count", wlog_a.size(), i + 1);
      if (wlog_a.size() == i + 1) begin
        check("wr_addr", wlog_a[i], a);
        check("wr_data", wlog_d[i], wdat[i]);
      end
      check("light_wr", light, wdat[i]);
      check("led_idx", led, seg_of((i + 1) % BURST_LEN));
      ref_mem[a] = wdat[i];
      wx ^= wdat[i];
    end
    for (int i = 0; i < BURST_LEN; i++) begin
      a = base + ADDR_W'(i);
      check("done_early", done, 0);
      press(DATA_W'($urandom));
      exp = ref_mem[a];
      if (fault_en && exp == 16'h0008) exp = exp | 16'h0001;
      rx ^= exp;
      check("light_rd", light, exp);
    end
    check("done_set", done, 1);
`ifdef SRAM_RDBK_CHECK_EN
    check("err_in_done", err, (wx != rx));
`endif
    check("wr_total", wlog_a.size(), BURST_LEN);
    press(DATA_W'($urandom));
    check("done_clear", done, 0);
`ifdef SRAM_RDBK_CHECK_EN
    check("err_clear", err, 0);
`endif
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_light"}, light, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_en"}, sram_if.Ram1EN, 1);
    check({pfx, "_oe"}, sram_if.Ram1OE, 1);
    check({pfx, "_we"}, sram_if.Ram1WE, 1);
    check({pfx, "_addr"}, sram_if.Ram1Addr, 0);
    check({pfx, "_led"}, led, 7'h40);
`ifdef SRAM_RDBK_CHECK_EN
    check({pfx, "_err"}, err, 0);
`endif
  endtask

  initial begin
    int guard;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    #2 rst_n = 1'b1;

    // Directed burst: base 0xF9 wraps past 0xFF to 0x00..0x02.
    wdat = '{16'h0007, 16'h0009, 16'h0008, 16'h0006, 16'h0004,
             16'h0005, 16'h0001, 16'h0002, 16'h0000, 16'h0003};
    run_burst(16'h00F9, 1'b0);

    // Random bursts. The second one has extra presses during a write.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < BURST_LEN; i++) wdat[i] = DATA_W'($urandom);
      run_burst(DATA_W'($urandom), b == 1);
    end

    // Assert reset during the WE-low phase of the 4th write.
    for (int i = 0; i < BURST_LEN; i++) wdat[i] = DATA_W'($urandom);
    press(16'h0040);
    for (int i = 0; i < 3; i++) press(wdat[i]);
    sw = wdat[3];
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    guard = 0;
    while (sram_if.Ram1WE && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("abort_we_low", sram_if.Ram1WE, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("abort");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // After reset the controller must start again from IDLE.
    for (int i = 0; i < BURST_LEN; i++) wdat[i] = DATA_W'($urandom);
    run_burst(DATA_W'($urandom_range(0, 255)), 1'b0);

`ifdef SRAM_RDBK_CHECK_EN
    fault_en = 1'b1;
    wdat = '{16'h0007, 16'h0009, 16'h0008, 16'h0006, 16'h0004,
             16'h0005, 16'h0001, 16'h0002, 16'h0000, 16'h0003};
    run_burst(16'h0010, 1'b0);
    fault_en = 1'b0;
`endif

    check("we_oe_overlap", overlap, 0);
    check("busy_vs_en", busy_bad, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/sram_burst_controller.md
SRAM_BURST_CONTROLLER -- requirements
Module: sram_burst_controller

Interface
REQ-001 SHALL provide parameter DATA_W, default 16: switch, display and SRAM data width.
REQ-002 SHALL provide parameter ADDR_W, default 18: SRAM address width.
REQ-003 SHALL provide parameter BURST_LEN, default 10, range 1..2^ADDR_W: words per write phase and per read phase.
REQ-004 SHALL provide parameter WAIT_CYC, default 1, range 1..15: cycles the WE/OE strobe stays active.
REQ-005 Port CLK, input, 1: single system clock; all state changes on its rising edge.
REQ-006 Port RST, input, 1: asynchronous, active-low reset.
REQ-007 Port SW, input, DATA_W: operator value, used as base address (low ADDR_W bits) or write data.
REQ-008 Port STEP, input, 1: asynchronous operator push button, active-high.
REQ-009 Port Light, output, DATA_W: last word written or read.
REQ-010 Port Ram1Addr, output, ADDR_W: SRAM address.
REQ-011 Port Ram1Data, inout, DATA_W: SRAM data bus; high-Z unless a write is in progress.
REQ-012 Ports Ram1EN, Ram1OE, Ram1WE, output, 1 each: active-low SRAM chip enable, output enable and write enable.
REQ-013 Port Led, output, 7: active-low seven-segment pattern (gfedcba) of the word index, bits [3:0].
REQ-014 Ports Busy and Done, output, 1 each: SRAM access in progress, and read phase complete.

Function
REQ-015 STEP SHALL pass through a 2-flop synchroniser and a rising-edge detector, giving a one-cycle step pulse 3 cycles after the STEP rise.
REQ-016 States SHALL be IDLE, WR_WAIT, WR_ACC, RD_WAIT, RD_ACC and DONE.
REQ-017 IDLE + step: base <= SW[ADDR_W-1:0], idx <= 0, go to WR_WAIT.
REQ-018 WR_WAIT + step: capture SW into the write register, go to WR_ACC.
REQ-019 WR_ACC, first cycle: drive Ram1Addr = base+idx, drive Ram1Data, Ram1EN=0, Ram1WE=1.
REQ-020 WR_ACC, next WAIT_CYC cycles: Ram1WE=0.
REQ-021 WR_ACC, final cycle: Ram1WE=1 with address and data still held; Light <= data.
REQ-022 WR_ACC total length SHALL be WAIT_CYC+2 cycles; the bus goes high-Z the cycle after.
REQ-023 After a write, idx SHALL increment; if idx reaches BURST_LEN, idx <= 0 and go to RD_WAIT, else go to WR_WAIT.
REQ-024 RD_WAIT + step: go to RD_ACC.
REQ-025 RD_ACC: first cycle Ram1EN=0 and address set; then Ram1OE=0 for WAIT_CYC cycles.
REQ-026 RD_ACC: Ram1Data SHALL be sampled into Light on the last OE-low cycle; OE deasserts the next cycle.
REQ-027 After a read, idx SHALL increment; the last read goes to DONE, otherwise back to RD_WAIT.
REQ-028 DONE: Done=1; a step returns to IDLE with Done=0.
REQ-029 Address arithmetic SHALL be modulo 2^ADDR_W; base+idx wraps past all-ones to 0.
REQ-030 Step pulses arriving while in WR_ACC or RD_ACC SHALL be dropped, not queued.
REQ-031 Busy=1 exactly during WR_ACC and RD_ACC.
REQ-032 Ram1WE and Ram1OE SHALL never be low in the same cycle.
REQ-033 Ram1EN=1 outside WR_ACC and RD_ACC.

Reset
REQ-034 On RST low, the block SHALL immediately enter IDLE, including mid-access.
REQ-035 Reset values: idx=0, base=0, Light=0, Led=pattern for 0, Busy=0, Done=0, Err=0, Ram1EN=1, Ram1OE=1, Ram1WE=1, Ram1Addr=0, Ram1Data high-Z, synchroniser flops cleared.

Configuration
REQ-036 With macro SRAM_RDBK_CHECK_EN defined, the block SHALL:
- add output Err (1 bit);
- XOR every written word into wsum and every read word into rsum, both cleared in IDLE;
- on entering DONE, set Err = (wsum != rsum); Err clears on leaving DONE.
REQ-037 Without SRAM_RDBK_CHECK_EN, no Err port and no checksum logic SHALL exist.

Verification
REQ-038 Default parameters: steps with SW = 0x00F9, then 0x0007,0x0009,0x0008,0x0006,0x0004,0x0005,0x0001,0x0002,0x0000,0x0003, then 10 more steps -> writes to 0x000F9..0x00102; reads return the same sequence on Light; Done=1.
REQ-039 ADDR_W=4, base SW=0x000E, BURST_LEN=3 -> write addresses 0xE, 0xF, 0x0.
REQ-040 WAIT_CYC=3 -> Ram1WE low exactly 3 cycles per write, Ram1OE low exactly 3 cycles per read; never both low.
REQ-041 STEP pulsed twice during one WR_ACC -> only 1 write occurs and idx advances by 1.
REQ-042 RST low during the WE-low cycle of the 4th write -> all outputs immediately take REQ-035 values; the next step restarts from IDLE.
REQ-043 With SRAM_RDBK_CHECK_EN, force Ram1Data bit 0 stuck-at-1 in the SRAM model on word 0x0008 -> Err=1 in DONE; with no fault -> Err=0.
